// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Request/response bundle for one requester of the data-memory arbiter.
//   req    requester -> arbiter  request, held with its attributes until ack
//   we     requester -> arbiter  1 = store, 0 = load
//   be     requester -> arbiter  store byte enables, be[i] selects wdata[8i+7:8i]
//   addr   requester -> arbiter  byte address, bits [1:0] ignored
//   wdata  requester -> arbiter  store data
//   ack    arbiter -> requester  one-cycle completion pulse
//   err    arbiter -> requester  pulses with ack for an out-of-range address
//   rdata  arbiter -> requester  load data, valid from ack and held until the next load
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one word-wide, big-endian data memory between two requesters (p0: load/store
// unit, p1: debug/loader) with round-robin arbitration. Sub-word stores become
// read-modify-write sequences. One transaction in flight; each completes with a one-cycle ack.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   p0, p1       requester bundles (slave side)
//   busy         high whenever the sequencer is not idle
//   mem_A        word-aligned memory address (0 when idle/done)
//   mem_WE       memory write enable (only in the write cycle)
//   mem_WD       memory write data (0 outside the write cycle)
//   mem_RD       combinational memory read data
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    output logic           busy,
    output logic [31:0]    mem_A,
    output logic           mem_WE,
    output logic [31:0]    mem_WD,
    input  logic [31:0]    mem_RD
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    // Winner selection and the winner's attributes, only meaningful in StIdle.
    logic        sel;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_base;
    logic [31:0] sel_wdata;
    logic        sel_oor;

    // Replace each enabled lane of the old word with the matching lane of the new data.
    // Lane i is byte address base+(3-i) in this big-endian memory; the merge is lane-wise.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = lanes[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        // On a tie the port that did not win last time goes next.
        if (p0.req && p1.req) begin
            sel = ~last_q;
        end else begin
            sel = p1.req;
        end
        sel_we    = sel ? p1.we    : p0.we;
        sel_be    = sel ? p1.be    : p0.be;
        sel_wdata = sel ? p1.wdata : p0.wdata;
        sel_base  = (sel ? p1.addr : p0.addr) & 32'hFFFF_FFFC;
        sel_oor   = sel_base >= 32'(MEM_BYTES);
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        mem_a_d  = mem_a_q;
        mem_we_d = mem_we_q;
        mem_wd_d = mem_wd_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack_d    = 2'b00;
        err_d    = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (p0.req || p1.req) begin
                    gnt_d   = sel;
                    last_d  = sel;
                    we_d    = sel_we;
                    be_d    = sel_be;
                    wdata_d = sel_wdata;
                    if (sel_oor) begin
                        state_d = StDone;
                        ack_d   = {sel, ~sel};
                        err_d   = {sel, ~sel};
                    end else if (sel_we && sel_be == 4'h0) begin
                        state_d = StDone;
                        ack_d   = {sel, ~sel};
                    end else if (sel_we && sel_be == 4'hF) begin
                        state_d  = StWr;
                        mem_a_d  = sel_base;
                        mem_we_d = 1'b1;
                        mem_wd_d = sel_wdata;
                    end else begin
                        // Loads and partial stores both read the word first.
                        state_d = StRd;
                        mem_a_d = sel_base;
                    end
                end
            end
            StRd: begin
                if (!we_q) begin
                    state_d = StDone;
                    ack_d   = {gnt_q, ~gnt_q};
                    mem_a_d = '0;
                    if (gnt_q) begin
                        rdata1_d = mem_RD;
                    end else begin
                        rdata0_d = mem_RD;
                    end
                end else begin
                    // mem_wd_q doubles as the merge register for the write cycle.
                    state_d  = StWr;
                    mem_we_d = 1'b1;
                    mem_wd_d = merge_lanes(mem_RD, wdata_q, be_q);
                end
            end
            StWr: begin
                state_d  = StDone;
                ack_d    = {gnt_q, ~gnt_q};
                mem_a_d  = '0;
                mem_we_d = 1'b0;
                mem_wd_d = '0;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= '0;
            mem_a_q  <= '0;
            mem_we_q <= 1'b0;
            mem_wd_q <= '0;
            ack_q    <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            mem_a_q  <= mem_a_d;
            mem_we_q <= mem_we_d;
            mem_wd_q <= mem_wd_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign busy     = state_q != StIdle;
    assign mem_A    = mem_a_q;
    assign mem_WE   = mem_we_q;
    assign mem_WD   = mem_wd_q;
    assign p0.ack   = ack_q[0];
    assign p1.ack   = ack_q[1];
    assign p0.err   = err_q[0];
    assign p1.err   = err_q[1];
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized two-port traffic.
// Expected responses are queued when a request is issued and checked by a monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter_if if0 ();
    dmem_arbiter_if if1 ();

    dmem_arbiter #(.MEM_BYTES(1024)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .p0     (if0),
        .p1     (if1),
        .busy   (busy),
        .mem_A  (mem_a),
        .mem_WE (mem_we),
        .mem_WD (mem_wd),
        .mem_RD (mem_rd)
    );

    // Memory environment: untouched words come from init_word().
    logic [31:0] mem [256];
    bit          wr_flag [256];

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'd4)  return 32'h1122_3344;
        if (idx == 8'd12) return 32'hAABB_CCDD;
        return {idx, ~idx, idx ^ 8'h5A, idx + 8'h33};
    endfunction

    function automatic logic [31:0] env_word(input logic [7:0] idx);
        return wr_flag[idx] ? mem[idx] : init_word(idx);
    endfunction

    assign mem_rd = env_word(mem_a[9:2]);

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[9:2]]     <= mem_wd;
            wr_flag[mem_a[9:2]] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        bit          err;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          lat;
        int          issue;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   ack_log[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: compares writes and acks against the queued expectations.
    initial begin
        wr_t  w;
        exp_t e;
        int   got_port;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                                 mem_a, mem_wd);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", mem_a, w.addr);
                        chk("wr_data", mem_wd, w.data);
                    end
                end
                if (if0.ack || if1.ack) begin
                    got_port = if1.ack ? (if0.ack ? 2 : 1) : 0;
                    ack_log.push_back(got_port);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: got port %0d, expected no ack", got_port);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port", 32'(got_port), 32'(e.port));
                        chk("err", {30'd0, if1.err, if0.err},
                            e.err ? (e.port == 1 ? 32'd2 : 32'd1) : 32'd0);
                        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                        chk("p0_rdata", if0.rdata, e.rd0);
                        chk("p1_rdata", if1.rdata, e.rd1);
                        chk("busy_at_ack", {31'd0, busy}, 32'd1);
                    end
                end
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd [2];
    int          last;
    bit          pend [2];
    bit          t_we [2];
    logic [3:0]  t_be [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wdata [2];

    task automatic drive(input int p, input bit rq);
        if (p == 0) begin
            if0.req = rq; if0.we = t_we[0]; if0.be = t_be[0];
            if0.addr = t_addr[0]; if0.wdata = t_wdata[0];
        end else begin
            if1.req = rq; if1.we = t_we[1]; if1.be = t_be[1];
            if1.addr = t_addr[1]; if1.wdata = t_wdata[1];
        end
    endtask

    task automatic raise(input int p, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        t_we[p] = we; t_be[p] = be; t_addr[p] = addr; t_wdata[p] = wdata;
        pend[p] = 1'b1;
        drive(p, 1'b1);
    endtask

    task automatic raise_random(input int p);
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        int          r;
        we = 1'($urandom_range(0, 1));
        r  = $urandom_range(0, 7);
        be = (r == 0) ? 4'h0 : (r <= 2) ? 4'hF : 4'($urandom_range(0, 15));
        addr = ($urandom_range(0, 9) == 0) ? 32'(1024 + $urandom_range(0, 70000))
                                           : 32'($urandom_range(0, 1023));
        raise(p, we, be, addr, $urandom);
    endtask

    // Predicts the result of granting port w now (called in the IDLE cycle it is sampled).
    task automatic predict(input int w);
        exp_t        e;
        wr_t         wr;
        logic [31:0] base;
        logic [31:0] old_word;
        logic [31:0] new_word;
        base    = t_addr[w] & 32'hFFFF_FFFC;
        e.port  = w;
        e.err   = 1'b0;
        e.issue = cyc;
        if (base >= 32'd1024) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!t_we[w]) begin
            exp_rd[w] = ref_mem[base[9:2]];
            e.lat = 2;
        end else if (t_be[w] == 4'h0) begin
            e.lat = 1;
        end else begin
            old_word = ref_mem[base[9:2]];
            new_word = old_word;
            for (int i = 0; i < 4; i++) begin
                if (t_be[w][i]) new_word[8*i +: 8] = t_wdata[w][8*i +: 8];
            end
            ref_mem[base[9:2]] = new_word;
            wr.addr = base;
            wr.data = new_word;
            wr_q.push_back(wr);
            e.lat = (t_be[w] == 4'hF) ? 2 : 3;
        end
        e.rd0 = exp_rd[0];
        e.rd1 = exp_rd[1];
        exp_q.push_back(e);
    endtask

    // Called at posedge+1 of an IDLE cycle with at least one request pending.
    task automatic serve(output int w);
        bit got;
        if (pend[0] && pend[1]) w = 1 - last;
        else                    w = pend[1] ? 1 : 0;
        last = w;
        predict(w);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if ((w == 0) ? if0.ack : if1.ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack on port %0d, expected one within 8 cycles", w);
        end
        @(posedge clk);
        #1;
        pend[w] = 1'b0;
        drive(w, 1'b0);
    endtask

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive(0, 1'b0); drive(1, 1'b0);
        exp_q.delete();
        wr_q.delete();
        last = 1;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        bit          found;
        logic [31:0] saved;
        logic [31:0] hold;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        t_we[0] = 1'b0; t_be[0] = 4'h0; t_addr[0] = '0; t_wdata[0] = '0;
        t_we[1] = 1'b0; t_be[1] = 4'h0; t_addr[1] = '0; t_wdata[1] = '0;
        model_reset();

        // Reset state.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #6;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_ack", {30'd0, if1.ack, if0.ack}, 32'd0);
        chk("rst_err", {30'd0, if1.err, if0.err}, 32'd0);
        chk("rst_p0_rdata", if0.rdata, 32'd0);
        chk("rst_p1_rdata", if1.rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // p0 load of a known word.
        raise(0, 1'b0, 4'h0, 32'h10, 32'h0);
        serve(w);
        chk("load_0x10", if0.rdata, 32'h1122_3344);

        // p1 full-word store.
        raise(1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        serve(w);
        chk("store_0x20", env_word(8'd8), 32'hDEAD_BEEF);

        // p0 partial store: lane 1 replaced (byte address 0x32).
        raise(0, 1'b1, 4'b0010, 32'h30, 32'h0000_EE00);
        serve(w);
        chk("rmw_0x30", env_word(8'd12), 32'hAABB_EEDD);

        // Continuous contention from reset: grants alternate starting with port 0.
        do_reset();
        ack_log.delete();
        raise(0, 1'b0, 4'h0, 32'h40, 32'h0);
        raise(1, 1'b0, 4'h0, 32'h44, 32'h0);
        for (int k = 0; k < 4; k++) begin
            serve(w);
            raise(w, 1'b0, 4'h0, 32'($urandom_range(0, 1023)), 32'h0);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive(0, 1'b0); drive(1, 1'b0);
        chk("fair_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() >= 4) begin
            chk("fair_0", 32'(ack_log[0]), 32'd0);
            chk("fair_1", 32'(ack_log[1]), 32'd1);
            chk("fair_2", 32'(ack_log[2]), 32'd0);
            chk("fair_3", 32'(ack_log[3]), 32'd1);
        end

        // Out-of-range load on p1: err, no memory access, rdata held.
        hold = exp_rd[1];
        raise(1, 1'b0, 4'h0, 32'h400, 32'h0);
        serve(w);
        chk("oor_rdata_hold", if1.rdata, hold);

        // Reset asserted during the write cycle of a partial store.
        saved = ref_mem[16];
        raise(0, 1'b1, 4'b1000, 32'h40, 32'hAB00_0000);
        last = 0;
        predict(0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (mem_we) found = 1'b1;
        end
        chk("rst_wr_seen", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wr_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ack", {30'd0, if1.ack, if0.ack}, 32'd0);
        ref_mem[16] = saved;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        raise(0, 1'b0, 4'h0, 32'h40, 32'h0);
        serve(w);

        // Randomized two-port traffic.
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) raise_random(p);
            end
            if (!pend[0] && !pend[1]) raise_random(0);
            serve(w);
        end
        while (pend[0] || pend[1]) serve(w);

        repeat (3) @(posedge clk);
        chk("leftover_acks", 32'(exp_q.size()), 32'd0);
        chk("leftover_writes", 32'(wr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
